// File: rtl/alu_operand_seq.sv
// rtl/alu_operand_seq.sv - operand fetch / issue / writeback stage feeding a combinational ALU
module alu_operand_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_ra,
  input  logic [2:0]       cmd_rb,
  input  logic [2:0]       cmd_rd,
  input  logic             ld_en,
  input  logic [2:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_rd,
  output logic             res_zero
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rf [8];
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [2:0]       op_q, rd_q;
  logic             accept;
  logic             issuing;
  logic             ld_blocked;

  assign accept     = cmd_valid && cmd_ready;
  assign issuing    = (state == ISSUE);
  // the ALU writeback owns rf[rd] during ISSUE; a colliding direct load is dropped
  assign ld_blocked = issuing && (ld_addr == rd_q);

  // operand registers feed the ALU directly, so they hold between issues
  assign alu_op = op_q;
  assign alu_a  = opa_q;
  assign alu_b  = opb_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic: one ISSUE cycle per accepted command
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output logic: only IDLE accepts, and never while reset is asserted
  always_comb begin
    cmd_ready = 1'b0;
    if (state == IDLE && !rst) cmd_ready = 1'b1;
  end

  // operand capture on accept, with same-cycle load bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else if (accept) begin
      op_q  <= cmd_op;
      rd_q  <= cmd_rd;
      opa_q <= (ld_en && ld_addr == cmd_ra) ? ld_data : rf[cmd_ra];
      opb_q <= (ld_en && ld_addr == cmd_rb) ? ld_data : rf[cmd_rb];
    end
  end

  // register file: direct loads in any state, ALU writeback at the end of ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (ld_en && !ld_blocked) rf[ld_addr] <= ld_data;
      if (issuing)              rf[rd_q]    <= alu_out;
    end
  end

  // result capture: strobe for one cycle, data held until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_zero  <= 1'b1;
    end else begin
      res_valid <= issuing;
      if (issuing) begin
        res_data <= alu_out;
        res_rd   <= rd_q;
        res_zero <= (alu_out == '0);
      end
    end
  end

endmodule
